// File: rtl/memory_defs.sv
// Shared encodings for the byte-serial RAM sequencer and its arbiter.
package memory_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Memory-mapped I/O window: address bits [17:16]
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_LSB    = 1'b1
  } req_id_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-way grant for the RAM port; one-hot grant pulse while the sequencer is idle.
// Latency: combinational grant in the IDLE cycle; last_grant registered on each grant.
// Backpressure: a requester is simply not granted until the sequencer returns to IDLE.
module memory_arbiter
  import memory_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic idle,
  input  logic icache_req,
  input  logic lsb_req,
  input  logic flush,
  output logic gnt_icache,
  output logic gnt_lsb
);

  req_id_t last_grant;
  logic    icache_eff;

  // A redirect makes the pending fetch stale, so it is not eligible this cycle
  assign icache_eff = icache_req && !flush;

  always_comb begin
    gnt_icache = 1'b0;
    gnt_lsb    = 1'b0;
    if (idle) begin
      if (icache_eff && lsb_req) begin
        if (last_grant == REQ_LSB) gnt_icache = 1'b1;
        else                       gnt_lsb    = 1'b1;
      end else if (icache_eff) begin
        gnt_icache = 1'b1;
      end else if (lsb_req) begin
        gnt_lsb = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ_ICACHE;
    end else if (rdy) begin
      if (gnt_icache)   last_grant <= REQ_ICACHE;
      else if (gnt_lsb) last_grant <= REQ_LSB;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Serialises icache/LSB accesses onto the byte-wide RAM port (optional MEM_IO_STALL_EN I/O write stall).
// Latency: read done in cycle N+2, write done in cycle N+1 after acceptance (N = 1/2/4 bytes).
// Backpressure: rdy low freezes everything; with MEM_IO_STALL_EN, I/O writes wait on io_buffer_full.
module memory_controller
  import memory_defs::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      icache_req,
  input  logic [ADDR_WIDTH-1:0]     icache_addr,
  output logic                      icache_done,
  output logic [31:0]               icache_data,
  input  logic                      lsb_req,
  input  logic                      lsb_wr,
  input  logic [1:0]                lsb_size,
  input  logic [31:0]               lsb_addr,
  input  logic [31:0]               lsb_wdata,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  input  logic                      flush,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);

  state_t      state_q, state_d;
  req_id_t     owner_q;
  logic [2:0]  cnt_q, len_q;
  logic [31:0] base_q, wdata_q, data_q;
  logic [31:0] byte_addr;
  logic [7:0]  wr_byte;
  logic        gnt_icache, gnt_lsb, io_hold, drive_a;

  assign byte_addr = base_q + {29'd0, cnt_q};

`ifdef MEM_IO_STALL_EN
  assign io_hold = (state_q == ST_WRITE) && (byte_addr[17:16] == IO_PREFIX) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_hold   = 1'b0;
`endif

  memory_arbiter u_arbiter (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .idle       (state_q == ST_IDLE),
    .icache_req (icache_req),
    .lsb_req    (lsb_req),
    .flush      (flush),
    .gnt_icache (gnt_icache),
    .gnt_lsb    (gnt_lsb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_icache || gnt_lsb) state_d = (gnt_lsb && lsb_wr) ? ST_WRITE : ST_READ;
      ST_READ: begin
        if (flush && owner_q == REQ_ICACHE) state_d = ST_IDLE;
        else if (cnt_q == len_q)            state_d = ST_DONE;
      end
      ST_WRITE: if (!io_hold && cnt_q == len_q - 3'd1) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_ICACHE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (gnt_icache || gnt_lsb) begin
          cnt_q   <= '0;
          data_q  <= '0;
          owner_q <= gnt_lsb ? REQ_LSB : REQ_ICACHE;
          len_q   <= gnt_lsb ? byte_count(lsb_size) : 3'd4;
          base_q  <= gnt_lsb ? lsb_addr : 32'(icache_addr);
          wdata_q <= lsb_wdata;
        end
        // The byte returned now belongs to the address driven last cycle
        ST_READ: begin
          if (cnt_q != 3'd0) data_q <= data_q | (32'(mem_din) << {cnt_q - 3'd1, 3'b000});
          cnt_q <= cnt_q + 3'd1;
        end
        ST_WRITE: if (!io_hold) cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0: wr_byte = wdata_q[7:0];
      2'd1: wr_byte = wdata_q[15:8];
      2'd2: wr_byte = wdata_q[23:16];
      2'd3: wr_byte = wdata_q[31:24];
      default: wr_byte = 8'h00;
    endcase
  end

  assign drive_a     = (state_q == ST_WRITE) || (state_q == ST_READ && cnt_q != len_q);
  assign mem_a       = drive_a ? byte_addr[MEM_ADDR_WIDTH-1:0] : '0;
  assign mem_dout    = (state_q == ST_WRITE) ? wr_byte : 8'h00;
  assign mem_wr      = (state_q == ST_WRITE) && rdy && !io_hold;
  assign icache_done = (state_q == ST_DONE) && (owner_q == REQ_ICACHE);
  assign lsb_done    = (state_q == ST_DONE) && (owner_q == REQ_LSB);
  assign icache_data = data_q;
  assign lsb_rdata   = data_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed vector table, multi-cycle corner sequences, random traffic vs a byte-array model.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        icache_req = 1'b0;
  logic [16:0] icache_addr = '0;
  logic        icache_done;
  logic [31:0] icache_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = '0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        flush = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  memory_controller dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_done(icache_done), .icache_data(icache_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM the DUT talks to, and an independent reference image
  logic [7:0] ram     [bit [31:0]];
  logic [7:0] ref_ram [bit [31:0]];

  function automatic logic [7:0] ram_byte(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input bit [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
    mem_din <= ram_byte(mem_a);
  end

  function automatic int n_bytes(input logic is_lsb, input logic [1:0] size);
    if (!is_lsb)        return 4;
    if (size == 2'b00)  return 1;
    if (size == 2'b01)  return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_byte(addr + 32'(k))) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wdata);
    for (int k = 0; k < n; k++) ref_ram[addr + 32'(k)] = 8'(wdata >> (8 * k));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One access from idle; checks the per-cycle pin pattern and returns data and done cycle
  task automatic run_txn(input logic is_lsb, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat, output logic bus_ok);
    int n, cyc;
    logic got;
    n = n_bytes(is_lsb, size);
    data = '0; lat = -1; bus_ok = 1'b1; got = 1'b0; cyc = 0;
    if (is_lsb) begin
      lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata; lsb_req = 1'b1;
    end else begin
      icache_addr = addr[16:0]; icache_req = 1'b1;
    end
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= n) begin
        if (mem_a !== addr + 32'(cyc - 1)) bus_ok = 1'b0;
        if (mem_wr !== wr) bus_ok = 1'b0;
        if (wr && mem_dout !== 8'(wdata >> (8 * (cyc - 1)))) bus_ok = 1'b0;
      end else begin
        if (mem_wr !== 1'b0) bus_ok = 1'b0;
        if (cyc == 0 && mem_a !== 32'h0) bus_ok = 1'b0;
      end
      if ((is_lsb ? icache_done : lsb_done) !== 1'b0) bus_ok = 1'b0;
      if ((is_lsb ? lsb_done : icache_done) === 1'b1) begin
        got = 1'b1; lat = cyc;
        data = is_lsb ? lsb_rdata : icache_data;
        if (mem_a !== 32'h0) bus_ok = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    icache_req = 1'b0; lsb_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_lsb;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] data, exp, addr, wdata;
    logic        bus_ok, ic_seen, bad, is_lsb, wr;
    logic [1:0]  size;
    int          lat, done_c, strobes, first_c, n, kind;
    int          order[$];
    logic        ic_drop, ls_drop;

    ram[32'h10] = 8'h13; ram[32'h11] = 8'h00; ram[32'h12] = 8'h00; ram[32'h13] = 8'h93;
    ref_ram[32'h10] = 8'h13; ref_ram[32'h11] = 8'h00; ref_ram[32'h12] = 8'h00; ref_ram[32'h13] = 8'h93;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_dones", {30'd0, icache_done, lsb_done}, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_icache_data", icache_data, 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);

    // Both requesting continuously from reset: grants must alternate starting with LSB
    icache_addr = 17'h10; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h10;
    icache_req = 1'b1; lsb_req = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      @(negedge clk);
      ic_drop = icache_done; ls_drop = lsb_done;
      if (icache_done === 1'b1) order.push_back(0);
      if (lsb_done === 1'b1) order.push_back(1);
      @(posedge clk); #1;
      icache_req = !ic_drop; lsb_req = !ls_drop;
    end
    icache_req = 1'b0; lsb_req = 1'b0;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; end
    check("arb_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) check("arb_order", 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // Directed vector table
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h00000010, 32'h0,        32'h93000013, 6};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h00000100, 32'hDEADBEEF, 32'h0,        5};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h00000102, 32'h0,        32'h0000DEAD, 4};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h00000101, 32'h0,        32'h000000BE, 3};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 32'h00000100, 32'h0,        32'hDEADBEEF, 6};
    vecs[5]  = '{1'b1, 1'b1, 2'b11, 32'hFFFFFFFE, 32'h11223344, 32'h0,        5};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h11223344, 6};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 32'h00000001, 32'h0,        32'h00000011, 3};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 32'h00000200, 32'hABCD1234, 32'h0,        3};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h00000200, 32'h0,        32'h00001234, 6};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 32'h00000203, 32'h77777755, 32'h0,        2};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h00000200, 32'h0,        32'h55001234, 6};
    foreach (vecs[i]) begin
      run_txn(vecs[i].is_lsb, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, data, lat, bus_ok);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_bus", i), {31'd0, bus_ok}, 32'd1);
      if (vecs[i].wr) model_write(vecs[i].addr, n_bytes(vecs[i].is_lsb, vecs[i].size), vecs[i].wdata);
      else check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // Flush in cycle 3 of a fetch: back to IDLE in cycle 4, pending LSB byte read granted there
    ic_seen = 1'b0; done_c = -1; data = '0;
    lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h100; icache_addr = 17'h10;
    for (int c = 0; c < 20; c++) begin
      icache_req = (c < 4); flush = (c == 3); lsb_req = (c >= 1) && (done_c < 0);
      @(negedge clk);
      if (icache_done === 1'b1) ic_seen = 1'b1;
      if (c == 4) check("flush_idle_mem_a", mem_a, 32'h0);
      if (c == 5) check("flush_lsb_mem_a", mem_a, 32'h100);
      if (lsb_done === 1'b1 && done_c < 0) begin done_c = c; data = lsb_rdata; end
      @(posedge clk); #1;
    end
    flush = 1'b0; icache_req = 1'b0; lsb_req = 1'b0;
    check("flush_no_icache_done", {31'd0, ic_seen}, 32'h0);
    check("flush_lsb_done_cycle", 32'(done_c), 32'd7);
    check("flush_lsb_data", data, 32'h000000EF);

    // Flush in IDLE suppresses the fetch for that cycle only
    done_c = -1; data = '0; icache_addr = 17'h10;
    for (int c = 0; c < 15; c++) begin
      icache_req = (done_c < 0); flush = (c == 0);
      @(negedge clk);
      if (icache_done === 1'b1 && done_c < 0) begin done_c = c; data = icache_data; end
      @(posedge clk); #1;
    end
    flush = 1'b0; icache_req = 1'b0;
    check("idle_flush_done_cycle", 32'(done_c), 32'd7);
    check("idle_flush_data", data, 32'h93000013);

    // rdy low for three cycles in the middle of a word write
    done_c = -1; strobes = 0; bad = 1'b0;
    lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h300; lsb_wdata = 32'h0A0B0C0D;
    for (int c = 0; c < 20; c++) begin
      rdy = !(c >= 2 && c <= 4); lsb_req = (done_c < 0);
      @(negedge clk);
      if (mem_wr === 1'b1) strobes++;
      if (!rdy && mem_wr !== 1'b0) bad = 1'b1;
      if (lsb_done === 1'b1 && done_c < 0) done_c = c;
      @(posedge clk); #1;
    end
    rdy = 1'b1; lsb_req = 1'b0;
    model_write(32'h300, 4, 32'h0A0B0C0D);
    check("rdy_no_strobe_when_low", {31'd0, bad}, 32'h0);
    check("rdy_strobes", 32'(strobes), 32'd4);
    check("rdy_done_cycle", 32'(done_c), 32'd8);
    check("rdy_ram", {ram_byte(32'h303), ram_byte(32'h302), ram_byte(32'h301), ram_byte(32'h300)}, 32'h0A0B0C0D);

    // Byte write into the I/O window with the output buffer full for a while
    done_c = -1; strobes = 0; first_c = -1;
    lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h0000005A;
    for (int c = 0; c < 20; c++) begin
      io_buffer_full = (c <= 5); lsb_req = (done_c < 0);
      @(negedge clk);
      if (mem_wr === 1'b1) begin strobes++; if (first_c < 0) first_c = c; end
      if (lsb_done === 1'b1 && done_c < 0) done_c = c;
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0; lsb_req = 1'b0;
    model_write(32'h30000, 1, 32'h5A);
    check("io_strobes", 32'(strobes), 32'd1);
`ifdef MEM_IO_STALL_EN
    check("io_strobe_cycle", 32'(first_c), 32'd6);
    check("io_done_cycle", 32'(done_c), 32'd7);
`else
    check("io_strobe_cycle", 32'(first_c), 32'd1);
    check("io_done_cycle", 32'(done_c), 32'd2);
`endif
    check("io_ram", {24'd0, ram_byte(32'h30000)}, 32'h5A);

    // Reset in the middle of a read abandons it
    lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h100; lsb_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; lsb_req = 1'b0;
    @(negedge clk);
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_rdata", lsb_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    ic_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (lsb_done === 1'b1 || icache_done === 1'b1) ic_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_done", {31'd0, ic_seen}, 32'h0);

    // Random single-requester traffic against the byte-array model
    for (int t = 0; t < 150; t++) begin
      kind   = $urandom_range(0, 2);
      is_lsb = (kind != 0);
      wr     = (kind == 2);
      size   = 2'($urandom_range(0, 3));
      if (!is_lsb || $urandom_range(0, 3) != 0) addr = 32'h400 + 32'($urandom_range(0, 63));
      else                                       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      wdata = $urandom;
      n     = n_bytes(is_lsb, size);
      exp   = model_read(addr, n);
      run_txn(is_lsb, wr, size, addr, wdata, data, lat, bus_ok);
      check("rnd_lat", 32'(lat), 32'(n + (wr ? 1 : 2)));
      check("rnd_bus", {31'd0, bus_ok}, 32'd1);
      if (wr) model_write(addr, n, wdata);
      else    check("rnd_data", data, exp);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Sequencer and arbiter for the single byte-wide RAM port. It serves two requesters, the instruction cache (word reads) and the load/store buffer (byte/half/word reads and writes). Each accepted access is serialised into byte transfers, and the little-endian word is assembled or split along the way. It sits between the core's memory clients and the top-level `mem_*` pins.

## Interface
- `ADDR_WIDTH`, 17: instruction-cache address width, zero-extended to 32 bits.
- `MEM_ADDR_WIDTH`, 32: RAM address width.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `rdy` input, 1: global enable; low freezes all state.
- `icache_req` input, 1: instruction word read request.
- `icache_addr` input, ADDR_WIDTH: fetch address.
- `icache_done` output, 1: one-cycle completion pulse.
- `icache_data` output, 32: fetched word, valid while `icache_done` is high.
- `lsb_req` input, 1: data access request.
- `lsb_wr` input, 1: 1 = write, 0 = read.
- `lsb_size` input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `lsb_addr` input, 32: data address.
- `lsb_wdata` input, 32: write data, low bytes used first.
- `lsb_done` output, 1: one-cycle completion pulse.
- `lsb_rdata` output, 32: read data, zero-extended, valid while `lsb_done` is high.
- `flush` input, 1: pipeline redirect; aborts an instruction fetch.
- `mem_din` input, 8: RAM read byte; valid the cycle after its address.
- `mem_dout` output, 8: RAM write byte.
- `mem_a` output, MEM_ADDR_WIDTH: RAM byte address.
- `mem_wr` output, 1: RAM write strobe.
- `io_buffer_full` input, 1: memory-mapped I/O output buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Requests are sampled only in IDLE.
- A requester holds its request and operands stable until its done pulse. It drops the request in the cycle after done.
- Arbitration in IDLE:
  - Only one requester high: grant it.
  - Both high: grant the LSB, unless the previous grant was the LSB, in which case grant the icache.
  - `last_grant` is updated on every grant.
- Byte count N: icache 4; LSB by size 1, 2 or 4.
- Byte k uses address base+k, modulo 2^32. No alignment is required.
- READ:
  - Drives `mem_a` = base+k for k = 0..N-1 on consecutive cycles.
  - Captures `mem_din` one cycle later into bits [8k+7:8k].
  - After byte N-1 is captured, goes to DONE.
- WRITE:
  - Drives `mem_a` = base+k, `mem_dout` = wdata[8k+7:8k] and `mem_wr` = 1 for k = 0..N-1.
  - After the last byte, goes to DONE.
- DONE:
  - Asserts the granted requester's done for exactly one cycle with the assembled data.
  - Returns to IDLE and accepts no request this cycle.
- `flush`:
  - During an icache READ: return to IDLE at the next edge; no `icache_done`.
  - In IDLE: suppresses acceptance of `icache_req` that cycle; `lsb_req` may still be granted.
  - LSB operations ignore `flush`.
  - If DONE is reached for the icache in the same cycle, `icache_done` is still issued.
- `rdy` low:
  - Holds all registers.
  - Forces `mem_wr` to 0 combinationally, so no byte is written twice.
- In IDLE and DONE: `mem_a` = 0, `mem_wr` = 0.

## Timing
- Reset values: state IDLE, `last_grant` = icache, `icache_done` = 0, `lsb_done` = 0, `icache_data` = 0, `lsb_rdata` = 0, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0.
- Reset mid-operation abandons the access; no done pulse is issued.
- Cycle 0 is the IDLE cycle in which the request is accepted.
- Read: addresses in cycles 1..N, last byte sampled at the end of cycle N+1, done in cycle N+2. Word read: done in cycle 6; byte read: cycle 3.
- Write: bytes in cycles 1..N, done in cycle N+1. Word write: done in cycle 5.
- The next acceptance is earliest in the cycle after DONE.

## Configuration
- `MEM_IO_STALL_EN` defined:
  - A WRITE whose address has bits [17:16] = 2'b11 (0x30000–0x3FFFF) holds its current byte while `io_buffer_full` = 1.
  - While held: `mem_wr` = 0 and the byte counter is frozen.
  - It resumes in the first cycle `io_buffer_full` = 0.
- `MEM_IO_STALL_EN` undefined: `io_buffer_full` is ignored; timing is as in Timing.

## Structure
- Shared package `memory_defs` holds:
  - size encodings (BYTE/HALF/WORD)
  - state encodings (IDLE/READ/WRITE/DONE)
  - the I/O address prefix 2'b11 at bits [17:16]
  - requester IDs (ICACHE/LSB)
- One sub-module, `memory_arbiter`:
  - Owns the grant decision and the `last_grant` register, with flush masking of `icache_req`.
  - Outputs a one-hot grant pulse in IDLE.
- `memory_controller` owns the state machine, byte counter, shift/assembly registers and pin drivers.

## Test plan
- `icache_req`, addr 0x0010, RAM bytes 13 00 00 93 at 0x10..0x13 -> `mem_a` 0x10..0x13 in cycles 1–4; `icache_done` in cycle 6 with `icache_data` = 0x93000013.
- LSB write of word 0xDEADBEEF to 0x100 -> `mem_wr` = 1 for cycles 1–4 with `mem_dout` EF, BE, AD, DE; `lsb_done` in cycle 5; a half read of 0x102 returns 0x0000DEAD.
- Both requesting continuously from reset -> grants alternate LSB, icache, LSB, icache; neither waits more than one foreign access.
- `flush` in cycle 3 of an icache read -> IDLE in cycle 4, no `icache_done`; a pending `lsb_req` is granted in cycle 4.
- `rdy` low for 3 cycles during a word write -> no `mem_wr` while low; exactly 4 write strobes in total; done delayed 3 cycles.
- `MEM_IO_STALL_EN` set, byte write to 0x30000 with `io_buffer_full` high for 5 cycles -> `mem_wr` stays 0 until it drops, then one strobe; done the following cycle.
